// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the fifo_arb burst arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Width of a requester index; never below one bit.
  function automatic int fifo_arb_idw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width of the beat counter, able to hold 0..BURST.
  function automatic int fifo_arb_cntw(input int b);
    return $clog2(b + 1);
  endfunction

endpackage

// File: rtl/fifo_arb_pick.sv
// Rotating priority encoder: first set bit of i_valid at or above i_base,
// wrapping modulo NUM_REQ. Tie i_base to zero for plain fixed priority.
module fifo_arb_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]               i_valid,
  input  logic [fifo_arb_idw(NUM_REQ)-1:0] i_base,
  output logic [fifo_arb_idw(NUM_REQ)-1:0] o_win,
  output logic                             o_any
);

  localparam int IDW = fifo_arb_idw(NUM_REQ);

  logic [IDW-1:0] w_idx;

  // Walk offsets from far to near so the nearest valid index is written last.
  always_comb begin
    w_idx = '0;
    o_win = '0;
    o_any = |i_valid;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = IDW'((int'(i_base) + k) % NUM_REQ);
      if (i_valid[w_idx]) o_win = w_idx;
    end
  end

endmodule

// File: rtl/fifo_arb.sv
// Burst arbiter in front of a shared FIFO write port. One requester is
// locked per grant and passed through combinationally until BURST beats
// have moved or the grantee drops valid.
// Build option: define FIFO_ARB_FIXED_PRIO_EN for lowest-index-wins
// arbitration; otherwise round-robin from a pointer past the last grantee.
module fifo_arb
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DIN     = 16,
  parameter int BURST   = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ*DIN-1:0]               din_data,
  input  logic [NUM_REQ-1:0]                   din_valid,
  output logic [NUM_REQ-1:0]                   din_ready,
  output logic                                 dout_valid,
  input  logic                                 dout_ready,
  output logic [DIN+fifo_arb_idw(NUM_REQ)-1:0] dout_data,
  output logic [fifo_arb_idw(NUM_REQ)-1:0]     grant_id,
  output logic                                 busy
);

  localparam int IDW = fifo_arb_idw(NUM_REQ);
  localparam int CW  = fifo_arb_cntw(BURST);

  arb_state_t     r_state, w_state_nxt;
  logic [IDW-1:0] r_grant_id;
  logic [CW-1:0]  r_beat_cnt;
  logic [IDW-1:0] w_win, w_base;
  logic           w_any, w_lock, w_gvalid, w_hs, w_last, w_release;

  assign w_lock   = (r_state == LOCK);
  assign w_gvalid = din_valid[r_grant_id];
  assign w_hs     = w_lock & w_gvalid & dout_ready;
  assign w_last   = (r_beat_cnt == CW'(BURST - 1));

  fifo_arb_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_valid (din_valid),
    .i_base  (w_base),
    .o_win   (w_win),
    .o_any   (w_any)
  );

`ifdef FIFO_ARB_FIXED_PRIO_EN
  assign w_base = '0;
`else
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] w_gid_inc;

  // Explicit wrap so non-power-of-two NUM_REQ never points past the last requester.
  assign w_gid_inc = (r_grant_id == IDW'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
  assign w_base    = r_rr_ptr;

  // Round-robin pointer moves past the grantee on every release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_rr_ptr <= '0;
    else if (w_release) r_rr_ptr <= w_gid_inc;
  end
`endif

  // Zero-latency passthrough of the locked requester.
  assign dout_valid = w_lock & w_gvalid;
  assign dout_data  = {r_grant_id, din_data[r_grant_id*DIN +: DIN]};
  assign grant_id   = r_grant_id;
  assign busy       = w_lock;

  // Only the grantee ever sees ready; nobody is ready while arbitrating.
  always_comb begin
    din_ready = '0;
    if (w_lock) din_ready[r_grant_id] = dout_ready;
  end

  // Next state: lock on any request, release on bubble or final beat.
  always_comb begin
    w_state_nxt = r_state;
    w_release   = 1'b0;
    case (r_state)
      IDLE: if (w_any) w_state_nxt = LOCK;
      LOCK: if (!w_gvalid || (dout_ready && w_last)) begin
        w_state_nxt = IDLE;
        w_release   = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Grant capture and beat counting; counted beats are dropped on release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant_id <= '0;
      r_beat_cnt <= '0;
    end else if (r_state == IDLE) begin
      if (w_any) begin
        r_grant_id <= w_win;
        r_beat_cnt <= '0;
      end
    end else if (w_release) begin
      r_beat_cnt <= '0;
    end else if (w_hs) begin
      r_beat_cnt <= r_beat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_arb.sv
// Self-checking bench for fifo_arb: directed scenarios plus a random run,
// all cross-checked every cycle against a transaction-level grant model
// and a per-requester payload sequence scoreboard.
module tb_fifo_arb;
  import fifo_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int B  = 8;
  localparam int IW = fifo_arb_idw(N);

  logic              clk, rst;
  logic [N*DW-1:0]   din_data;
  logic [N-1:0]      din_valid, din_ready;
  logic              dout_valid, dout_ready;
  logic [IW+DW-1:0]  dout_data;
  logic [IW-1:0]     grant_id;
  logic              busy;

  int checks, errors;

  // sources: enable, beats left (-1 = unlimited), index of next item
  logic [N-1:0] en;
  int           left [N];
  int           sidx [N];
  int           ocnt [N];
  logic [DW-1:0] seed;

  // reference model state
  logic m_busy;
  int   m_gid, m_cnt, m_ptr;

  // per-cycle snapshot taken mid-cycle
  logic [N-1:0] s_valid, s_hs_in, s_hs_out;
  logic         s_ready;

  fifo_arb #(.NUM_REQ(N), .DIN(DW), .BURST(B)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_data   (din_data),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pay(int i, int k);
    return DW'(i * 4099 + k * 40503 + 17) ^ seed;
  endfunction

  always_comb begin
    din_valid = '0;
    din_data  = '0;
    for (int i = 0; i < N; i++) begin
      din_valid[i]          = en[i] && (left[i] != 0);
      din_data[i*DW +: DW]  = pay(i, sidx[i]);
    end
  end

  function automatic int first_valid(logic [N-1:0] v, int base);
    for (int k = 0; k < N; k++)
      if (v[(base + k) % N]) return (base + k) % N;
    return 0;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    step();
    en = '0;
    for (int i = 0; i < N; i++) left[i] = -1;
    repeat (4) step();
  endtask

  // Advance the model once per cycle from the mid-cycle snapshot.
  task automatic model_loop();
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        m_busy = 1'b0; m_gid = 0; m_cnt = 0; m_ptr = 0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (s_hs_in[i]) begin
            sidx[i]++;
            if (left[i] > 0) left[i]--;
          end
          if (s_hs_out[i]) ocnt[i]++;
        end
        if (!m_busy) begin
          if (s_valid != '0) begin
`ifdef FIFO_ARB_FIXED_PRIO_EN
            m_gid = first_valid(s_valid, 0);
`else
            m_gid = first_valid(s_valid, m_ptr);
`endif
            m_busy = 1'b1;
            m_cnt  = 0;
          end
        end else if (!s_valid[m_gid] || (s_ready && m_cnt == B - 1)) begin
          m_busy = 1'b0;
          m_ptr  = (m_gid + 1) % N;
        end else if (s_ready) begin
          m_cnt++;
        end
      end
    end
  endtask

  // Every-cycle comparison of all outputs against the model and sources.
  task automatic scoreboard_monitor();
    logic          exp_v;
    logic [N-1:0]  exp_rdy;
    logic [IW+DW-1:0] exp_d;
    forever begin
      @(negedge clk);
      s_valid  = din_valid;
      s_ready  = dout_ready;
      s_hs_in  = din_valid & din_ready;
      s_hs_out = '0;
      if (!rst) begin
        checks++;
        if (busy !== 1'b0 || dout_valid !== 1'b0 || din_ready !== '0 || grant_id !== '0) begin
          errors++;
          $display("FAIL mon_reset t=%0t busy=%b dv=%b rdy=%b gid=%0d, want all 0", $time, busy, dout_valid, din_ready, grant_id);
        end
      end else begin
        exp_v   = m_busy && din_valid[m_gid];
        exp_rdy = (m_busy && dout_ready) ? (N'(1) << m_gid) : '0;
        checks++;
        if (busy !== m_busy) begin
          errors++; $display("FAIL mon_busy t=%0t got=%b exp=%b", $time, busy, m_busy);
        end
        if (m_busy) begin
          checks++;
          if (grant_id !== IW'(m_gid)) begin
            errors++; $display("FAIL mon_gid t=%0t got=%0d exp=%0d", $time, grant_id, m_gid);
          end
        end
        checks++;
        if (dout_valid !== exp_v) begin
          errors++; $display("FAIL mon_dvalid t=%0t got=%b exp=%b", $time, dout_valid, exp_v);
        end
        checks++;
        if (din_ready !== exp_rdy) begin
          errors++; $display("FAIL mon_ready t=%0t got=%b exp=%b", $time, din_ready, exp_rdy);
        end
        if (exp_v) begin
          exp_d = {IW'(m_gid), pay(m_gid, sidx[m_gid])};
          checks++;
          if (dout_data !== exp_d) begin
            errors++; $display("FAIL mon_data t=%0t got=%h exp=%h", $time, dout_data, exp_d);
          end
        end
        checks++;
        if ($countones(s_hs_in) != ((dout_valid === 1'b1 && dout_ready) ? 1 : 0)) begin
          errors++; $display("FAIL mon_hs_pair t=%0t in_hs=%b out_hs=%b", $time, s_hs_in, dout_valid & dout_ready);
        end
        if (dout_valid === 1'b1 && dout_ready) s_hs_out[dout_data[DW +: IW]] = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; en = '0; dout_ready = 1'b0;
    repeat (3) step();
    en = '1; dout_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dout_valid !== 1'b0 || din_ready !== '0 || grant_id !== '0) begin
      errors++;
      $display("FAIL reset_hold busy=%b dv=%b rdy=%b gid=%0d, want all 0", busy, dout_valid, din_ready, grant_id);
    end
    step();
    en = '0;
    #1 rst = 1'b1;
  endtask

  task automatic test_round_robin();
    int g, beats, idle, exp;
    logic pb;
    g = 0; beats = 0; idle = 0; pb = 1'b0;
    step();
    en = '1; dout_ready = 1'b1;
    for (int c = 0; c < 46; c++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        if (!pb) begin
`ifdef FIFO_ARB_FIXED_PRIO_EN
          exp = 0;
`else
          exp = g % N;
`endif
          checks++;
          if (grant_id !== IW'(exp)) begin
            errors++; $display("FAIL rr_order grant=%0d got=%0d exp=%0d", g, grant_id, exp);
          end
          checks++;
          if (idle != 1) begin
            errors++; $display("FAIL rr_gap grant=%0d idle=%0d exp=1", g, idle);
          end
          g++; idle = 0; beats = 0;
        end
        if (dout_valid === 1'b1 && dout_ready) beats++;
      end else begin
        if (pb) begin
          checks++;
          if (beats != B) begin
            errors++; $display("FAIL rr_beats grant=%0d got=%0d exp=%0d", g - 1, beats, B);
          end
        end
        idle++;
      end
      pb = busy;
    end
    checks++;
    if (g != 5) begin
      errors++; $display("FAIL rr_count got=%0d exp=5", g);
    end
    drain();
  endtask

  task automatic test_single_req();
    int beats, bubble, exp;
    logic found;
    beats = 0; bubble = 0; found = 1'b0;
    left[2] = 3; en = 4'b0100; dout_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        if (dout_valid === 1'b1) begin
          beats++;
          checks++;
          if (dout_data[DW +: IW] !== IW'(2)) begin
            errors++; $display("FAIL single_tag got=%0d exp=2", dout_data[DW +: IW]);
          end
        end else bubble++;
      end
    end
    checks++;
    if (beats != 3) begin
      errors++; $display("FAIL single_beats got=%0d exp=3", beats);
    end
    checks++;
    if (bubble != 1) begin
      errors++; $display("FAIL single_release bubble_cycles=%0d exp=1", bubble);
    end
    step();
    for (int i = 0; i < N; i++) left[i] = -1;
    en = 4'b1001;
`ifdef FIFO_ARB_FIXED_PRIO_EN
    exp = 0;
`else
    exp = 3;
`endif
    for (int c = 0; c < 5 && !found; c++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        found = 1'b1;
        checks++;
        if (grant_id !== IW'(exp)) begin
          errors++; $display("FAIL single_ptr got=%0d exp=%0d", grant_id, exp);
        end
      end
    end
    if (!found) begin
      checks++; errors++; $display("FAIL single_ptr_timeout got=no grant exp=grant");
    end
    drain();
  endtask

  task automatic test_backpressure();
    int beats, rem;
    beats = 0; rem = 0;
    en = 4'b0010; dout_ready = 1'b1;
    for (int c = 0; c < 20 && beats < 3; c++) begin
      @(negedge clk);
      if (busy === 1'b1 && dout_valid === 1'b1 && dout_ready) beats++;
    end
    checks++;
    if (beats != 3) begin
      errors++; $display("FAIL bp_start beats=%0d exp=3", beats);
    end
    step();
    dout_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || grant_id !== IW'(1) || din_ready !== '0 || dout_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold c=%0d busy=%b gid=%0d rdy=%b dv=%b exp busy=1 gid=1 rdy=0 dv=1", c, busy, grant_id, din_ready, dout_valid);
      end
    end
    step();
    dout_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      if (dout_valid === 1'b1) rem++;
    end
    checks++;
    if (rem != B - 3) begin
      errors++; $display("FAIL bp_remaining got=%0d exp=%0d", rem, B - 3);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int beats;
    logic found;
    beats = 0; found = 1'b0;
    en = 4'b1000; dout_ready = 1'b1;
    for (int c = 0; c < 20 && beats < 5; c++) begin
      @(negedge clk);
      if (busy === 1'b1 && dout_valid === 1'b1) beats++;
    end
    step();
    #1 rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || dout_valid !== 1'b0 || din_ready !== '0 || grant_id !== '0) begin
      errors++;
      $display("FAIL rstmid_out beats=%0d busy=%b dv=%b rdy=%b gid=%0d, want all 0", beats, busy, dout_valid, din_ready, grant_id);
    end
    en = 4'b1010;
    repeat (2) step();
    #1 rst = 1'b1;
    for (int c = 0; c < 5 && !found; c++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        found = 1'b1;
        checks++;
        if (grant_id !== IW'(1)) begin
          errors++; $display("FAIL rstmid_grant got=%0d exp=1", grant_id);
        end
      end
    end
    if (!found) begin
      checks++; errors++; $display("FAIL rstmid_timeout got=no grant exp=grant");
    end
    drain();
  endtask

`ifdef FIFO_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    en = 4'b1001;
    for (int c = 0; c < 300; c++) begin
      step();
      dout_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (busy === 1'b1) begin
        checks++;
        if (grant_id === IW'(3)) begin
          errors++; $display("FAIL fixed_starve c=%0d got=3 exp=0", c);
        end
      end
    end
    drain();
  endtask
`endif

  task automatic test_random();
    int total;
    total = 0;
    for (int c = 0; c < 1500; c++) begin
      step();
      if ($urandom_range(0, 3) == 0) en = N'($urandom);
      dout_ready = ($urandom_range(0, 3) != 0);
    end
    drain();
    for (int i = 0; i < N; i++) begin
      total += sidx[i];
      checks++;
      if (ocnt[i] != sidx[i]) begin
        errors++; $display("FAIL rand_count req=%0d out=%0d in=%0d", i, ocnt[i], sidx[i]);
      end
    end
    checks++;
    if (total < 100) begin
      errors++; $display("FAIL rand_activity beats=%0d exp>=100", total);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; en = '0; dout_ready = 1'b0;
    seed = DW'($urandom);
    for (int i = 0; i < N; i++) begin
      left[i] = -1; sidx[i] = 0; ocnt[i] = 0;
    end
    m_busy = 1'b0; m_gid = 0; m_cnt = 0; m_ptr = 0;
    s_valid = '0; s_hs_in = '0; s_hs_out = '0; s_ready = 1'b0;
    fork
      scoreboard_monitor();
      model_loop();
    join_none
    test_reset();
    test_round_robin();
    test_single_req();
    test_backpressure();
    test_reset_mid();
`ifdef FIFO_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
